// File: rtl/hnoc_out_arbiter_if.sv
// hnoc_out_arbiter_if: bundles the two requester handshakes and the output
// link of one hnoc_out_arbiter. The arbiter binds to the slave modport and the
// surrounding switch (or a bench) binds to the master modport.
// Optional macro HNOC_ARB_STATS_EN adds the statistics counter outputs.
interface hnoc_out_arbiter_if #(
  parameter int DataWidth = 36,
  parameter int CntWidth  = 16
);
  // Requester A
  logic [DataWidth-1:0] i_data_a;
  logic                 i_data_valid_a;
  logic                 o_data_ready_a;
  // Requester B
  logic [DataWidth-1:0] i_data_b;
  logic                 i_data_valid_b;
  logic                 o_data_ready_b;
  // Output link
  logic [DataWidth-1:0] o_data;
  logic                 o_data_valid;
  logic                 i_data_ready;
`ifdef HNOC_ARB_STATS_EN
  logic [CntWidth-1:0]  o_grant_cnt_a;
  logic [CntWidth-1:0]  o_grant_cnt_b;
  logic [CntWidth-1:0]  o_conflict_cnt;

  modport slave (
    input  i_data_a, i_data_valid_a,
    output o_data_ready_a,
    input  i_data_b, i_data_valid_b,
    output o_data_ready_b,
    output o_data, o_data_valid,
    input  i_data_ready,
    output o_grant_cnt_a, o_grant_cnt_b, o_conflict_cnt
  );

  modport master (
    output i_data_a, i_data_valid_a,
    input  o_data_ready_a,
    output i_data_b, i_data_valid_b,
    input  o_data_ready_b,
    input  o_data, o_data_valid,
    output i_data_ready,
    input  o_grant_cnt_a, o_grant_cnt_b, o_conflict_cnt
  );
`else
  modport slave (
    input  i_data_a, i_data_valid_a,
    output o_data_ready_a,
    input  i_data_b, i_data_valid_b,
    output o_data_ready_b,
    output o_data, o_data_valid,
    input  i_data_ready
  );

  modport master (
    output i_data_a, i_data_valid_a,
    input  o_data_ready_a,
    output i_data_b, i_data_valid_b,
    input  o_data_ready_b,
    input  o_data, o_data_valid,
    output i_data_ready
  );
`endif
endinterface

// File: rtl/hnoc_out_arbiter.sv
// hnoc_out_arbiter: two-input round-robin arbiter feeding one registered
// output flit slot. Flits are opaque; the arbiter only orders, holds and
// forwards them. A drain and a load may happen in the same cycle, giving
// one flit per cycle under sustained traffic.
// Optional macro HNOC_ARB_STATS_EN adds saturating grant/conflict counters.
module hnoc_out_arbiter #(
  parameter int DataWidth = 36,
  parameter int AddrWidth = 4,
  parameter int CntWidth  = 16
) (
  input  logic                  i_sclk,
  input  logic                  i_reset,
  hnoc_out_arbiter_if.slave     bus
);

  // Round-robin pointer: which requester was served by the most recent load.
  typedef enum logic {
    LAST_A = 1'b0,
    LAST_B = 1'b1
  } last_grant_e;

  last_grant_e          last_q, last_d;
  logic [DataWidth-1:0] data_q, data_d;
  logic                 valid_q, valid_d;

  logic can_load;
  logic grant_a, grant_b;
  logic ready_a, ready_b;
  logic load;
  logic both_valid;

  // The address field sits inside the opaque flit and is never decoded.
  logic [AddrWidth-1:0] unused_addr;
  assign unused_addr = bus.i_data_a[AddrWidth-1:0];

  // Output slot can accept a flit when empty or draining this cycle.
  always_comb begin
    can_load   = ~valid_q | bus.i_data_ready;
    both_valid = bus.i_data_valid_a & bus.i_data_valid_b;
    grant_a    = bus.i_data_valid_a & (~bus.i_data_valid_b | (last_q == LAST_B));
    grant_b    = bus.i_data_valid_b & (~bus.i_data_valid_a | (last_q == LAST_A));
    ready_a    = can_load & grant_a;
    ready_b    = can_load & grant_b;
    load       = ready_a | ready_b;
  end

  assign bus.o_data_ready_a = ready_a;
  assign bus.o_data_ready_b = ready_b;
  assign bus.o_data         = data_q;
  assign bus.o_data_valid   = valid_q;

  // Pointer register: holds across idle and stalled cycles.
  always_ff @(posedge i_sclk or posedge i_reset) begin
    if (i_reset) begin
      last_q <= LAST_B;
    end else begin
      last_q <= last_d;
    end
  end

  // Pointer next state: moves only when a flit is actually loaded.
  always_comb begin
    last_d = last_q;
    if (ready_a) begin
      last_d = LAST_A;
    end else if (ready_b) begin
      last_d = LAST_B;
    end
  end

  // Output slot next state: load wins over drain so drain+load has no bubble.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (load) begin
      data_d  = ready_a ? bus.i_data_a : bus.i_data_b;
      valid_d = 1'b1;
    end else if (bus.i_data_ready) begin
      valid_d = 1'b0;
    end
  end

  // Output slot register.
  always_ff @(posedge i_sclk or posedge i_reset) begin
    if (i_reset) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

`ifdef HNOC_ARB_STATS_EN
  logic [CntWidth-1:0] cnt_a_q, cnt_a_d;
  logic [CntWidth-1:0] cnt_b_q, cnt_b_d;
  logic [CntWidth-1:0] cnt_c_q, cnt_c_d;

  // Saturating counter increments; counters stick at all-ones.
  always_comb begin
    cnt_a_d = cnt_a_q;
    cnt_b_d = cnt_b_q;
    cnt_c_d = cnt_c_q;
    if (ready_a && (cnt_a_q != '1)) begin
      cnt_a_d = cnt_a_q + 1'b1;
    end
    if (ready_b && (cnt_b_q != '1)) begin
      cnt_b_d = cnt_b_q + 1'b1;
    end
    if (load && both_valid && (cnt_c_q != '1)) begin
      cnt_c_d = cnt_c_q + 1'b1;
    end
  end

  // Statistics registers.
  always_ff @(posedge i_sclk or posedge i_reset) begin
    if (i_reset) begin
      cnt_a_q <= '0;
      cnt_b_q <= '0;
      cnt_c_q <= '0;
    end else begin
      cnt_a_q <= cnt_a_d;
      cnt_b_q <= cnt_b_d;
      cnt_c_q <= cnt_c_d;
    end
  end

  assign bus.o_grant_cnt_a  = cnt_a_q;
  assign bus.o_grant_cnt_b  = cnt_b_q;
  assign bus.o_conflict_cnt = cnt_c_q;
`else
  logic unused_both_valid;
  assign unused_both_valid = both_valid;
`endif

endmodule

// File: tb/tb_hnoc_out_arbiter.sv
// tb_hnoc_out_arbiter: directed and randomized traffic against a
// transaction-level reference model with a scoreboard of expected output flits.
module tb_hnoc_out_arbiter;
  localparam int DW = 36;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  hnoc_out_arbiter_if #(.DataWidth(DW), .CntWidth(CW)) bus ();

  hnoc_out_arbiter #(.DataWidth(DW), .AddrWidth(4), .CntWidth(CW)) dut (
    .i_sclk (clk),
    .i_reset(rst),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state (transaction level)
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] out_log[$];
  bit m_full = 0, m_full_nxt = 0;
  bit m_last_a = 0;           // 1 when the last served requester was A
  bit exp_rdy_a = 0, exp_rdy_b = 0;
  int unsigned m_cnt_a = 0, m_cnt_b = 0, m_cnt_c = 0;
  localparam int unsigned CMAX = (1 << CW) - 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares handshake and output against the model each cycle.
  always @(negedge clk) begin
    if (!rst) begin
      check("ready_a", 64'(bus.o_data_ready_a), 64'(exp_rdy_a));
      check("ready_b", 64'(bus.o_data_ready_b), 64'(exp_rdy_b));
      check("valid", 64'(bus.o_data_valid), 64'(m_full));
      if (m_full) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL data actual=%0h expected=<none queued>", bus.o_data);
        end else begin
          check("data", 64'(bus.o_data), 64'(exp_q[0]));
          if (bus.i_data_ready) begin
            out_log.push_back(bus.o_data);
            void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  // One cycle of stimulus plus the model's decision for that cycle.
  task automatic drive_cycle(input bit va, input logic [DW-1:0] da,
                             input bit vb, input logic [DW-1:0] db,
                             input bit rdy, output bit acc_a, output bit acc_b);
    bit can, win_a, win_b;
    @(posedge clk);
    #1;
    m_full = m_full_nxt;
    bus.i_data_valid_a = va;
    bus.i_data_a       = da;
    bus.i_data_valid_b = vb;
    bus.i_data_b       = db;
    bus.i_data_ready   = rdy;
    can   = !m_full || rdy;
    // Single requester always wins; on contention the one not served last wins.
    win_a = va && (!vb || !m_last_a);
    win_b = vb && (!va || m_last_a);
    exp_rdy_a = can && win_a;
    exp_rdy_b = can && win_b;
    if (exp_rdy_a) begin
      exp_q.push_back(da);
      m_last_a = 1;
      if (m_cnt_a < CMAX) m_cnt_a++;
    end
    if (exp_rdy_b) begin
      exp_q.push_back(db);
      m_last_a = 0;
      if (m_cnt_b < CMAX) m_cnt_b++;
    end
    if ((exp_rdy_a || exp_rdy_b) && va && vb && m_cnt_c < CMAX) m_cnt_c++;
    m_full_nxt = (exp_rdy_a || exp_rdy_b) ? 1'b1 : (rdy ? 1'b0 : m_full);
    acc_a = exp_rdy_a;
    acc_b = exp_rdy_b;
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_full = 0;
    m_full_nxt = 0;
    m_last_a = 0;
    exp_rdy_a = 0;
    exp_rdy_b = 0;
    m_cnt_a = 0;
    m_cnt_b = 0;
    m_cnt_c = 0;
    bus.i_data_valid_a = 0;
    bus.i_data_valid_b = 0;
    bus.i_data_ready   = 1;
  endtask

  // Asynchronous reset in mid-cycle; output valid must drop before the next edge.
  task automatic async_reset();
    @(posedge clk);
    #2;
    rst = 1;
    #1;
    check("async_valid", 64'(bus.o_data_valid), 64'd0);
    check("async_data", 64'(bus.o_data), 64'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 0;
  endtask

  initial begin
    bit aa, ab;
    bit pa, pb;
    logic [DW-1:0] fa, fb;
    int unsigned ia, ib;

    bus.i_data_a = '0;
    bus.i_data_b = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    check("reset_valid", 64'(bus.o_data_valid), 64'd0);
    check("reset_data", 64'(bus.o_data), 64'd0);
    check("reset_ready_a", 64'(bus.o_data_ready_a), 64'd0);
    check("reset_ready_b", 64'(bus.o_data_ready_b), 64'd0);
    rst = 0;

    // A only: ready in cycle 0, flit visible in cycle 1.
    drive_cycle(1, 36'h123456789, 0, '0, 1, aa, ab);
    #1 check("a_only_ready", 64'(bus.o_data_ready_a), 64'd1);
    drive_cycle(0, '0, 0, '0, 1, aa, ab);
    #1 check("a_only_data", 64'(bus.o_data), 64'h123456789);
    check("a_only_valid", 64'(bus.o_data_valid), 64'd1);

    // Continuous contention after reset: strict A,B alternation with no bubbles.
    async_reset();
    out_log.delete();
    ia = 0;
    ib = 0;
    for (int c = 0; c < 8; c++) begin
      drive_cycle(1, DW'(8'hA0 + ia), 1, DW'(8'hB0 + ib), 1, aa, ab);
      if (aa) ia++;
      if (ab) ib++;
    end
    drive_cycle(0, '0, 0, '0, 1, aa, ab);
    drive_cycle(0, '0, 0, '0, 1, aa, ab);
    check("alt_count", 64'(out_log.size()), 64'd8);
    for (int k = 0; k < 8 && k < out_log.size(); k++) begin
      logic [DW-1:0] want;
      want = (k % 2 == 0) ? DW'(8'hA0 + k / 2) : DW'(8'hB0 + k / 2);
      check("alt_order", 64'(out_log[k]), 64'(want));
    end

    // Backpressure: A0 held for 5 stalled cycles, B0 follows on release.
    async_reset();
    drive_cycle(1, DW'(8'hA0), 1, DW'(8'hB0), 1, aa, ab);
    for (int c = 0; c < 5; c++) begin
      drive_cycle(1, DW'(8'hA1), 1, DW'(8'hB0), 0, aa, ab);
      #1 check("stall_data", 64'(bus.o_data), 64'hA0);
    end
    drive_cycle(1, DW'(8'hA1), 1, DW'(8'hB0), 1, aa, ab);
    drive_cycle(0, '0, 0, '0, 0, aa, ab);
    #1 check("release_data", 64'(bus.o_data), 64'hB0);

    // Reset while holding a flit, then contention must favour A.
    async_reset();
    drive_cycle(1, DW'(8'hC0), 1, DW'(8'hD0), 1, aa, ab);
    #1 check("post_reset_grant_a", 64'(bus.o_data_ready_a), 64'd1);
    drive_cycle(0, '0, 1, DW'(8'hD0), 1, aa, ab);

    // Pointer hold: B alone, idle 3 cycles, then contention grants A.
    async_reset();
    drive_cycle(0, '0, 1, DW'(8'hB7), 1, aa, ab);
    repeat (3) drive_cycle(0, '0, 0, '0, 1, aa, ab);
    drive_cycle(1, DW'(8'hA7), 1, DW'(8'hB8), 1, aa, ab);
    #1 check("hold_grant_a", 64'(bus.o_data_ready_a), 64'd1);
    check("hold_no_b", 64'(bus.o_data_ready_b), 64'd0);
    drive_cycle(0, '0, 1, DW'(8'hB8), 1, aa, ab);

`ifdef HNOC_ARB_STATS_EN
    // 20 cycles of contention: 10/10 grants, conflict counter saturates at 15.
    async_reset();
    for (int c = 0; c < 20; c++) begin
      drive_cycle(1, DW'(c), 1, DW'(c + 100), 1, aa, ab);
    end
    drive_cycle(0, '0, 0, '0, 1, aa, ab);
    #1;
    check("stat_a", 64'(bus.o_grant_cnt_a), 64'd10);
    check("stat_b", 64'(bus.o_grant_cnt_b), 64'd10);
    check("stat_conflict", 64'(bus.o_conflict_cnt), 64'd15);
`endif

    // Randomized traffic; requesters hold a flit until it is accepted.
    async_reset();
    pa = 0;
    pb = 0;
    fa = '0;
    fb = '0;
    for (int c = 0; c < 400; c++) begin
      if (!pa && ($urandom_range(2) != 0)) begin
        pa = 1;
        fa = DW'({$urandom(), $urandom()});
      end
      if (!pb && ($urandom_range(2) != 0)) begin
        pb = 1;
        fb = DW'({$urandom(), $urandom()});
      end
      drive_cycle(pa, fa, pb, fb, ($urandom_range(9) < 7), aa, ab);
      if (aa) pa = 0;
      if (ab) pb = 0;
    end
    repeat (3) drive_cycle(0, '0, 0, '0, 1, aa, ab);
    #1;
    check("drain_empty", 64'(exp_q.size()), 64'd0);
`ifdef HNOC_ARB_STATS_EN
    check("rand_stat_a", 64'(bus.o_grant_cnt_a), 64'(m_cnt_a));
    check("rand_stat_b", 64'(bus.o_grant_cnt_b), 64'(m_cnt_b));
    check("rand_stat_c", 64'(bus.o_conflict_cnt), 64'(m_cnt_c));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
